// File: rtl/tmul_pkg.sv
// Shared types for the TMUL operand sequencer: state encoding, datapath widths
// and the {valid, lane} tag that follows each issue through the FMA pipeline.
package tmul_pkg;

    localparam int OP_W  = 32;
    localparam int ACC_W = 64;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN_P0 = 3'd1,
        S_RUN_P1 = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic valid;
        logic lane;
    } tag_t;

endpackage

// File: rtl/fma_issue_tracker.sv
// Two-stage tag pipeline mirroring the FMA latency, plus the select that
// forwards a lane's in-flight sum straight back into the FMA c input.
module fma_issue_tracker
    import tmul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_issue_valid,
    input  logic             i_issue_lane,
    input  logic [ACC_W-1:0] i_fma_out,
    input  logic [ACC_W-1:0] i_acc0,
    input  logic [ACC_W-1:0] i_acc1,
    output logic             o_tag1_valid,
    output tag_t             o_tag2,
    output logic [ACC_W-1:0] o_fwd_c
);

    tag_t r_tag1;
    tag_t r_tag2;

    // Shift each issue's tag along so stage 2 lines up with its FMA result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag1 <= '{valid: 1'b0, lane: 1'b0};
            r_tag2 <= '{valid: 1'b0, lane: 1'b0};
        end else begin
            r_tag2 <= r_tag1;
            r_tag1 <= '{valid: i_issue_valid, lane: i_issue_lane};
        end
    end

    // The lane's freshest sum is on fma_out when stage 2 holds that same lane.
    always_comb begin
        o_fwd_c = i_issue_lane ? i_acc1 : i_acc0;
        if (r_tag2.valid && (r_tag2.lane == i_issue_lane)) begin
            o_fwd_c = i_fma_out;
        end else begin
            o_fwd_c = i_issue_lane ? i_acc1 : i_acc0;
        end
    end

    assign o_tag1_valid = r_tag1.valid;
    assign o_tag2       = r_tag2;

endmodule

// File: rtl/fma_dot_seq.sv
// Operand sequencer for the shared 32x32+64 FMA: interleaves two dot-product
// lanes so each lane's running sum can be fed back across the 2-cycle latency.
module fma_dot_seq
    import tmul_pkg::*;
#(
    parameter int K_MAX = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [ACC_W-1:0] c_init0,
    input  logic [ACC_W-1:0] c_init1,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a0,
    input  logic [OP_W-1:0]  in_b0,
    input  logic [OP_W-1:0]  in_a1,
    input  logic [OP_W-1:0]  in_b1,
    output logic [OP_W-1:0]  fma_a,
    output logic [OP_W-1:0]  fma_b,
    output logic [ACC_W-1:0] fma_c,
    input  logic [ACC_W-1:0] fma_out,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] res0,
    output logic [ACC_W-1:0] res1,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc0;
    logic [ACC_W-1:0] r_acc1;
    logic [ACC_W-1:0] w_acc0_nxt;
    logic [ACC_W-1:0] w_acc1_nxt;
    logic [ACC_W-1:0] r_res0;
    logic [ACC_W-1:0] r_res1;
    logic [ACC_W-1:0] w_fwd_c;
    logic [LEN_W-1:0] r_cnt;
    logic [OP_W-1:0]  r_hold_a;
    logic [OP_W-1:0]  r_hold_b;
    logic [OP_W-1:0]  w_fma_a;
    logic [OP_W-1:0]  w_fma_b;
    logic             r_done;
    logic             r_err;
    logic             w_issue_valid;
    logic             w_issue_lane;
    logic             w_in_ready;
    logic             w_len_ok;
    logic             w_accept;
    logic             w_finish;
    logic             w_tag1_valid;
    tag_t             w_tag2;

    assign w_len_ok = (len != {LEN_W{1'b0}}) && (len <= LEN_W'(K_MAX));
    assign w_accept = (r_state == S_IDLE) && start && w_len_ok;
    // Leaving DRAIN once stage 1 is empty means the last result lands this cycle.
    assign w_finish = (r_state == S_DRAIN) && !w_tag1_valid;

    assign w_acc0_nxt = (w_tag2.valid && !w_tag2.lane) ? fma_out : r_acc0;
    assign w_acc1_nxt = (w_tag2.valid &&  w_tag2.lane) ? fma_out : r_acc1;

    fma_issue_tracker u_tracker (
        .clk           (clk),
        .rst           (rst),
        .i_issue_valid (w_issue_valid),
        .i_issue_lane  (w_issue_lane),
        .i_fma_out     (fma_out),
        .i_acc0        (r_acc0),
        .i_acc1        (r_acc1),
        .o_tag1_valid  (w_tag1_valid),
        .o_tag2        (w_tag2),
        .o_fwd_c       (w_fwd_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and issue selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_issue_valid = 1'b0;
        w_issue_lane  = 1'b0;
        w_fma_a       = {OP_W{1'b0}};
        w_fma_b       = {OP_W{1'b0}};
        w_in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN_P0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN_P0: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_issue_valid = 1'b1;
                    w_issue_lane  = 1'b0;
                    w_fma_a       = in_a0;
                    w_fma_b       = in_b0;
                    w_state_nxt   = S_RUN_P1;
                end else begin
                    w_state_nxt = S_RUN_P0;
                end
            end
            S_RUN_P1: begin
                w_issue_valid = 1'b1;
                w_issue_lane  = 1'b1;
                w_fma_a       = r_hold_a;
                w_fma_b       = r_hold_b;
                if (r_cnt == LEN_W'(1)) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_RUN_P0;
                end
            end
            S_DRAIN: begin
                if (w_finish) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Accumulators, step counter, lane-1 holding register and result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc0   <= {ACC_W{1'b0}};
            r_acc1   <= {ACC_W{1'b0}};
            r_cnt    <= {LEN_W{1'b0}};
            r_hold_a <= {OP_W{1'b0}};
            r_hold_b <= {OP_W{1'b0}};
            r_res0   <= {ACC_W{1'b0}};
            r_res1   <= {ACC_W{1'b0}};
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc0 <= c_init0;
                r_acc1 <= c_init1;
                r_cnt  <= len;
            end else begin
                r_acc0 <= w_acc0_nxt;
                r_acc1 <= w_acc1_nxt;
                if (r_state == S_RUN_P1) begin
                    r_cnt <= r_cnt - LEN_W'(1);
                end
            end
            if ((r_state == S_RUN_P0) && in_valid) begin
                r_hold_a <= in_a1;
                r_hold_b <= in_b1;
            end
            // Results are taken from the post-capture sums so they appear with done.
            if (w_finish) begin
                r_res0 <= w_acc0_nxt;
                r_res1 <= w_acc1_nxt;
            end
            r_done <= w_finish;
            r_err  <= (r_state == S_IDLE) && start && !w_len_ok;
        end
    end

    assign in_ready = w_in_ready;
    assign fma_a    = w_fma_a;
    assign fma_b    = w_fma_b;
    assign fma_c    = w_issue_valid ? w_fwd_c : {ACC_W{1'b0}};
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign res0     = r_res0;
    assign res1     = r_res1;
    assign err      = r_err;

endmodule
